// File: rtl/sub_share_arb.sv
// rtl/sub_share_arb.sv - round-robin scheduler sharing one external W-bit subtractor among NREQ requesters
// Optional floor saturation of the result on borrow: define SUB_ARB_SAT_EN.
module sub_share_arb #(
  parameter int NREQ = 3,
  parameter int W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [W-1:0]      sub_a,
  output logic [W-1:0]      sub_b,
  input  logic [W-1:0]      sub_d,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      diff,
  output logic              borrow
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   owner, owner_n;
  logic [NREQ-1:0] grant_n;
  logic            busy_n;
  logic [NREQ-1:0] done_n;
  logic [W-1:0]    sub_a_n, sub_b_n;
  logic            borrow_r, borrow_r_n;
  logic [W-1:0]    diff_n;
  logic            borrow_n;

  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] pick_onehot;
  logic [W-1:0]    sel_a, sel_b;

  // Requester index reached 'off' steps after 'base', wrapping at NREQ.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = rr_index(ptr, j);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_onehot = '0;
    sel_a       = '0;
    sel_b       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PW'(i)) begin
        pick_onehot[i] = 1'b1;
        sel_a          = a_in[i*W +: W];
        sel_b          = b_in[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      done     <= '0;
      sub_a    <= '0;
      sub_b    <= '0;
      borrow_r <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      grant    <= grant_n;
      busy     <= busy_n;
      done     <= done_n;
      sub_a    <= sub_a_n;
      sub_b    <= sub_b_n;
      borrow_r <= borrow_r_n;
      diff     <= diff_n;
      borrow   <= borrow_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    grant_n    = grant;
    busy_n     = busy;
    done_n     = '0;
    sub_a_n    = sub_a;
    sub_b_n    = sub_b;
    borrow_r_n = borrow_r;
    diff_n     = diff;
    borrow_n   = borrow;
    case (state)
      IDLE: begin
        if (found) begin
          owner_n    = pick;
          grant_n    = pick_onehot;
          sub_a_n    = sel_a;
          sub_b_n    = sel_b;
          borrow_r_n = (sel_a < sel_b);
          busy_n     = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        // Subtractor output settles from the registered operands this cycle.
        state_n = CAPTURE;
      end
      CAPTURE: begin
`ifdef SUB_ARB_SAT_EN
        diff_n = borrow_r ? '0 : sub_d;
`else
        diff_n = sub_d;
`endif
        borrow_n = borrow_r;
        done_n   = grant;
        grant_n  = '0;
        busy_n   = 1'b0;
        ptr_n    = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sub_share_arb.sv
// tb/tb_sub_share_arb.sv - directed self-checking bench for sub_share_arb
module tb_sub_share_arb;

`ifdef SUB_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [26:0] a_in = '0;
  logic [26:0] b_in = '0;
  logic [8:0]  sub_a, sub_b, sub_d, diff;
  logic [2:0]  grant, done;
  logic        busy, borrow;

  int n_cmp = 0;
  int n_err = 0;

  sub_share_arb #(.NREQ(3), .W(9)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .sub_a(sub_a), .sub_b(sub_b), .sub_d(sub_d),
    .grant(grant), .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  // External shared subtractor
  assign sub_d = sub_a - sub_b;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*9 +: 9] = 9'(a);
    b_in[i*9 +: 9] = 9'(b);
  endtask

  // One transaction starting from IDLE with req already driven.
  task automatic xact(input string tag, input logic [2:0] g, input int d, input int bo);
    step();
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy1"}, 32'(busy), 32'd1);
    chk({tag, ".done_early"}, 32'(done), 32'd0);
    step();
    chk({tag, ".busy2"}, 32'(busy), 32'd1);
    chk({tag, ".done_issue"}, 32'(done), 32'd0);
    step();
    chk({tag, ".done"}, 32'(done), 32'(g));
    chk({tag, ".diff"}, 32'(diff), 32'(d));
    chk({tag, ".borrow"}, 32'(borrow), 32'(bo));
    chk({tag, ".grant_clr"}, 32'(grant), 32'd0);
    chk({tag, ".busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.borrow", 32'(borrow), 32'd0);
    chk("rst.sub_a", 32'(sub_a), 32'd0);
    chk("rst.sub_b", 32'(sub_b), 32'd0);
    rst = 1'b0;

    // 1: basic subtraction
    set_op(0, 300, 45);
    req = 3'b001;
    xact("t1", 3'b001, 255, 0);
    req = 3'b000;
    step();
    chk("t1.done_pulse", 32'(done), 32'd0);
    chk("t1.diff_hold", 32'(diff), 32'd255);

    // 2: borrow case
    set_op(0, 10, 20);
    req = 3'b001;
    xact("t2", 3'b001, SAT ? 0 : 502, 1);
    req = 3'b000;

    // 3: round-robin with all requesters held, starting from fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(0, 100, 1);
    set_op(1, 50, 60);
    set_op(2, 400, 399);
    req = 3'b111;
    xact("t3a", 3'b001, 99, 0);
    xact("t3b", 3'b010, SAT ? 0 : 502, 1);
    xact("t3c", 3'b100, 1, 0);
    xact("t3d", 3'b001, 99, 0);
    req = 3'b000;

    // 4: boundary operands
    set_op(0, 511, 511);
    req = 3'b001;
    xact("t4a", 3'b001, 0, 0);
    set_op(0, 0, 511);
    xact("t4b", 3'b001, SAT ? 0 : 1, 1);
    req = 3'b000;

    // 5: req dropped and operand changed after grant
    set_op(1, 100, 30);
    req = 3'b010;
    step();
    chk("t5.grant", 32'(grant), 32'd2);
    chk("t5.sub_a", 32'(sub_a), 32'd100);
    req = 3'b000;
    set_op(1, 5, 3);
    step();
    chk("t5.grant_hold", 32'(grant), 32'd2);
    chk("t5.sub_a_hold", 32'(sub_a), 32'd100);
    step();
    chk("t5.done", 32'(done), 32'd2);
    chk("t5.diff", 32'(diff), 32'd70);
    chk("t5.borrow", 32'(borrow), 32'd0);

    // 6: reset during ISSUE aborts; pointer returns to 0
    set_op(0, 7, 3);
    req = 3'b001;
    step();
    chk("t6.grant", 32'(grant), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6.rst_grant", 32'(grant), 32'd0);
    chk("t6.rst_busy", 32'(busy), 32'd0);
    chk("t6.rst_sub_a", 32'(sub_a), 32'd0);
    chk("t6.rst_diff", 32'(diff), 32'd0);
    chk("t6.rst_done", 32'(done), 32'd0);
    step();
    chk("t6.rst_done2", 32'(done), 32'd0);
    req = 3'b110;
    set_op(1, 200, 55);
    set_op(2, 9, 9);
    rst = 1'b0;
    xact("t6b", 3'b010, 145, 0);
    req = 3'b000;
    step();
    chk("t6.idle_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
